// File: rtl/ball_motion_ctrl_if.sv
// Frame-rate control and status bundle between the ball physics block and its neighbours.
interface ball_motion_ctrl_if;
    logic       frame_tick;
    logic       serve;
    logic [9:0] board_pos;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [1:0] state;

    modport master (
        output frame_tick, serve, board_pos,
        input  ball_x, ball_y, hit, miss, score, lives, game_over, state
    );

    modport slave (
        input  frame_tick, serve, board_pos,
        output ball_x, ball_y, hit, miss, score, lives, game_over, state
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame pong ball physics: position, wall/paddle reflection, serve, miss, lives and score.
// Optional BALL_SPEEDUP_EN: step grows by one after every 4th paddle hit, capped at 2*STEP.
module ball_motion_ctrl #(
    parameter int SCR_W       = 320,
    parameter int SCR_H       = 240,
    parameter int BALL_SIZE   = 15,
    parameter int BOARD_W     = 30,
    parameter int BOARD_Y     = 190,
    parameter int STEP        = 2,
    parameter int START_X     = 152,
    parameter int START_Y     = 60,
    parameter int MISS_FRAMES = 60,
    parameter int LIVES       = 3
) (
    input  logic              clk,
    input  logic              rst,
    ball_motion_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_MISS = 2'd2,
        S_OVER = 2'd3
    } state_e;

    localparam int          CW    = $clog2(MISS_FRAMES + 1);
    localparam logic [10:0] X_MAX = 11'(SCR_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX = 11'(SCR_H - BALL_SIZE);
    localparam logic [10:0] BS    = 11'(BALL_SIZE);
    localparam logic [10:0] BY    = 11'(BOARD_Y);
    localparam logic [10:0] BW    = 11'(BOARD_W);
    localparam logic [9:0]  SX    = 10'(START_X);
    localparam logic [9:0]  SY    = 10'(START_Y);

    state_e        state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          dxr_q, dxr_d;   // 1 = moving right
    logic          dyd_q, dyd_d;   // 1 = moving down
    logic          hit_q, hit_d, miss_q, miss_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [10:0]   xe, ye, bpe, step;
    logic          paddle;

`ifdef BALL_SPEEDUP_EN
    logic [10:0] step_q, step_d;
    logic [1:0]  hcnt_q, hcnt_d;
    assign step = step_q;
`else
    assign step = 11'(STEP);
`endif

    assign xe  = {1'b0, x_q};
    assign ye  = {1'b0, y_q};
    assign bpe = {1'b0, bus.board_pos};

    // Wall tests are rearranged as x+step >= limit so nothing underflows.
    assign paddle = (ye + BS <= BY) && (ye + BS + step >= BY) &&
                    (xe + BS > bpe) && (xe < bpe + BW);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dxr_d   = dxr_q;
        dyd_d   = dyd_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q;
        lives_d = lives_q;
        fcnt_d  = fcnt_q;
`ifdef BALL_SPEEDUP_EN
        step_d  = step_q;
        hcnt_d  = hcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                x_d = SX;
                y_d = SY;
                if (bus.serve) begin
                    state_d = S_MOVE;
                    dxr_d   = 1'b1;
                    dyd_d   = 1'b0;
`ifdef BALL_SPEEDUP_EN
                    step_d  = 11'(STEP);
                    hcnt_d  = 2'd0;
`endif
                end
            end
            S_MOVE: if (bus.frame_tick) begin
                if (dxr_q) begin
                    if (xe + step >= X_MAX) begin
                        x_d   = 10'(X_MAX);
                        dxr_d = 1'b0;
                    end else x_d = 10'(xe + step);
                end else begin
                    if (xe <= step) begin
                        x_d   = 10'd0;
                        dxr_d = 1'b1;
                    end else x_d = 10'(xe - step);
                end

                if (!dyd_q) begin
                    if (ye <= step) begin
                        y_d   = 10'd0;
                        dyd_d = 1'b1;
                    end else y_d = 10'(ye - step);
                end else if (paddle) begin
                    y_d   = 10'(BY - BS);
                    dyd_d = 1'b0;
                    hit_d = 1'b1;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
`ifdef BALL_SPEEDUP_EN
                    hcnt_d = hcnt_q + 2'd1;
                    if (hcnt_q == 2'd3 && step_q < 11'(2 * STEP)) step_d = step_q + 11'd1;
`endif
                end else if (ye + step >= Y_MAX) begin
                    y_d     = 10'(Y_MAX);
                    miss_d  = 1'b1;
                    lives_d = lives_q - 2'd1;
                    fcnt_d  = '0;
                    state_d = (lives_q == 2'd1) ? S_OVER : S_MISS;
                end else y_d = 10'(ye + step);
            end
            S_MISS: if (bus.frame_tick) begin
                if (fcnt_q == CW'(MISS_FRAMES - 1)) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                    x_d     = SX;
                    y_d     = SY;
                    dxr_d   = 1'b1;
                    dyd_d   = 1'b0;
                end else fcnt_d = fcnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= SX;
            y_q     <= SY;
            dxr_q   <= 1'b1;
            dyd_q   <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= 8'd0;
            lives_q <= 2'(LIVES);
            fcnt_q  <= '0;
`ifdef BALL_SPEEDUP_EN
            step_q  <= 11'(STEP);
            hcnt_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dxr_q   <= dxr_d;
            dyd_q   <= dyd_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            lives_q <= lives_d;
            fcnt_q  <= fcnt_d;
`ifdef BALL_SPEEDUP_EN
            step_q  <= step_d;
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign bus.ball_x    = x_q;
    assign bus.ball_y    = y_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = (state_q == S_OVER);
    assign bus.state     = state_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: spec-level model feeds a scoreboard, scenario tasks add fixed-value checks.
module tb_ball_motion_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ball_motion_ctrl_if bus();
    ball_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hit;
        logic       miss;
        logic [7:0] score;
        logic [1:0] lives;
        logic       go;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int m_x, m_y, m_st, m_lives, m_score, m_cnt, m_step, m_hc, m_bp;
    bit m_dxr, m_dyd;

    task automatic model_reset();
        m_x = 152; m_y = 60; m_st = 0; m_lives = 3; m_score = 0; m_cnt = 0;
        m_step = 2; m_hc = 0; m_dxr = 1; m_dyd = 0;
    endtask

    // Spec-level behaviour; pushes the expected post-edge outputs for every active cycle.
    task automatic model_cycle(input bit tk, input bit sv);
        exp_t e;
        int ox, oy;
        bit h, m;
        h = 0; m = 0; ox = m_x; oy = m_y;
        case (m_st)
            0: if (sv) begin m_st = 1; m_dxr = 1; m_dyd = 0; m_step = 2; m_hc = 0; end
            1: if (tk) begin
                if (m_dxr) begin
                    if (ox >= 320 - 15 - m_step) begin m_x = 305; m_dxr = 0; end
                    else m_x = ox + m_step;
                end else begin
                    if (ox <= m_step) begin m_x = 0; m_dxr = 1; end
                    else m_x = ox - m_step;
                end
                if (!m_dyd) begin
                    if (oy <= m_step) begin m_y = 0; m_dyd = 1; end
                    else m_y = oy - m_step;
                end else if (oy + 15 <= 190 && oy + 15 + m_step >= 190 &&
                             ox + 15 > m_bp && ox < m_bp + 30) begin
                    m_y = 175; m_dyd = 0; h = 1;
                    if (m_score < 255) m_score++;
`ifdef BALL_SPEEDUP_EN
                    m_hc++;
                    if (m_hc == 4) begin m_hc = 0; if (m_step < 4) m_step++; end
`endif
                end else if (oy >= 240 - 15 - m_step) begin
                    m_y = 225; m = 1; m_cnt = 0;
                    m_st = (m_lives == 1) ? 3 : 2;
                    m_lives--;
                end else m_y = oy + m_step;
            end
            2: if (tk) begin
                m_cnt++;
                if (m_cnt == 60) begin
                    m_st = 0; m_cnt = 0; m_x = 152; m_y = 60; m_dxr = 1; m_dyd = 0;
                end
            end
            default: ;
        endcase
        if (tk || sv) begin
            e.x = 10'(m_x); e.y = 10'(m_y); e.hit = h; e.miss = m;
            e.score = 8'(m_score); e.lives = 2'(m_lives);
            e.go = (m_st == 3); e.st = 2'(m_st);
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: every cycle that sampled a tick or serve produces one expected entry.
    always @(posedge clk) begin
        bit   act;
        exp_t g, e;
        act = (bus.frame_tick || bus.serve) && !rst;
        if (act) begin
            #1;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: DUT output with no expected entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                g.x = bus.ball_x; g.y = bus.ball_y; g.hit = bus.hit; g.miss = bus.miss;
                g.score = bus.score; g.lives = bus.lives; g.go = bus.game_over; g.st = bus.state;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL sb_frame: got x=%0d y=%0d hit=%0b miss=%0b sc=%0d lv=%0d go=%0b st=%0d exp x=%0d y=%0d hit=%0b miss=%0b sc=%0d lv=%0d go=%0b st=%0d",
                             g.x, g.y, g.hit, g.miss, g.score, g.lives, g.go, g.st,
                             e.x, e.y, e.hit, e.miss, e.score, e.lives, e.go, e.st);
                end
            end
        end
    end

    task automatic cyc(input bit tk, input bit sv);
        @(negedge clk);
        bus.frame_tick = tk;
        bus.serve      = sv;
        model_cycle(tk, sv);
        @(posedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.frame_tick = 1'b0; bus.serve = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        bus.board_pos = 10'd0; m_bp = 0;
        do_reset();
        n_cmp++;
        if (bus.ball_x !== 10'd152 || bus.ball_y !== 10'd60) begin
            n_err++; $display("FAIL reset_pos: got (%0d,%0d) exp (152,60)", bus.ball_x, bus.ball_y);
        end
        n_cmp++;
        if ({bus.hit, bus.miss, bus.game_over, bus.state} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got hit=%0b miss=%0b go=%0b st=%0d exp all 0",
                              bus.hit, bus.miss, bus.game_over, bus.state);
        end
        n_cmp++;
        if (bus.score !== 8'd0 || bus.lives !== 2'd3) begin
            n_err++; $display("FAIL reset_score_lives: got %0d/%0d exp 0/3", bus.score, bus.lives);
        end
        ticks(3);
        n_cmp++;
        if (bus.state !== 2'd0 || bus.ball_y !== 10'd60) begin
            n_err++; $display("FAIL idle_no_move: got st=%0d y=%0d exp 0/60", bus.state, bus.ball_y);
        end
    endtask

    task automatic test_serve_move();
        do_reset();
        cyc(1'b0, 1'b1);
        ticks(10);
        n_cmp++;
        if (bus.ball_x !== 10'd172 || bus.ball_y !== 10'd40 || bus.state !== 2'd1) begin
            n_err++; $display("FAIL move10: got (%0d,%0d) st=%0d exp (172,40) st=1",
                              bus.ball_x, bus.ball_y, bus.state);
        end
        ticks(20);
        n_cmp++;
        if (bus.ball_y !== 10'd0 || bus.ball_x !== 10'd212) begin
            n_err++; $display("FAIL top_wall: got (%0d,%0d) exp (212,0)", bus.ball_x, bus.ball_y);
        end
        ticks(1);
        n_cmp++;
        if (bus.ball_y !== 10'd2 || bus.ball_x !== 10'd214) begin
            n_err++; $display("FAIL top_bounce: got (%0d,%0d) exp (214,2)", bus.ball_x, bus.ball_y);
        end
        ticks(46);
        n_cmp++;
        if (bus.ball_x !== 10'd305) begin
            n_err++; $display("FAIL right_wall: got x=%0d exp 305", bus.ball_x);
        end
        ticks(1);
        n_cmp++;
        if (bus.ball_x !== 10'd303) begin
            n_err++; $display("FAIL right_bounce: got x=%0d exp 303", bus.ball_x);
        end
    endtask

    task automatic test_serve_with_tick();
        do_reset();
        cyc(1'b1, 1'b1);
        #2;
        n_cmp++;
        if (bus.state !== 2'd1 || bus.ball_x !== 10'd152 || bus.ball_y !== 10'd60) begin
            n_err++; $display("FAIL serve_tick_same: got st=%0d (%0d,%0d) exp 1 (152,60)",
                              bus.state, bus.ball_x, bus.ball_y);
        end
        ticks(1);
        n_cmp++;
        if (bus.ball_x !== 10'd154 || bus.ball_y !== 10'd58) begin
            n_err++; $display("FAIL first_step: got (%0d,%0d) exp (154,58)", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_paddle();
        do_reset();
        bus.board_pos = 10'd239; m_bp = 239;
        cyc(1'b0, 1'b1);
        ticks(117);
        n_cmp++;
        if (bus.ball_x !== 10'd225 || bus.ball_y !== 10'd174 || bus.hit !== 1'b0) begin
            n_err++; $display("FAIL pre_hit: got (%0d,%0d) hit=%0b exp (225,174) 0",
                              bus.ball_x, bus.ball_y, bus.hit);
        end
        ticks(1);
        n_cmp++;
        if (bus.ball_y !== 10'd175 || bus.hit !== 1'b1 || bus.score !== 8'd1) begin
            n_err++; $display("FAIL paddle_hit: got y=%0d hit=%0b score=%0d exp 175 1 1",
                              bus.ball_y, bus.hit, bus.score);
        end
        cyc(1'b0, 1'b0);
        #2;
        n_cmp++;
        if (bus.hit !== 1'b0) begin
            n_err++; $display("FAIL hit_pulse_len: got %0b exp 0", bus.hit);
        end
        ticks(1);
        n_cmp++;
        if (bus.ball_y !== 10'd173 || bus.ball_x !== 10'd221) begin
            n_err++; $display("FAIL after_hit: got (%0d,%0d) exp (221,173)", bus.ball_x, bus.ball_y);
        end
        // Mid-flight reset, then the strict x+BALL_SIZE > board_pos edge must not score.
        do_reset();
        bus.board_pos = 10'd240; m_bp = 240;
        cyc(1'b0, 1'b1);
        ticks(118);
        n_cmp++;
        if (bus.ball_y !== 10'd176 || bus.score !== 8'd0 || bus.state !== 2'd1) begin
            n_err++; $display("FAIL paddle_edge: got y=%0d score=%0d st=%0d exp 176 0 1",
                              bus.ball_y, bus.score, bus.state);
        end
    endtask

    task automatic test_miss_over();
        do_reset();
        bus.board_pos = 10'd0; m_bp = 0;
        for (int r = 0; r < 3; r++) begin
            cyc(1'b0, 1'b1);
            ticks(143);
            n_cmp++;
            if (bus.ball_y !== 10'd225 || bus.miss !== 1'b1 || bus.lives !== 2'(2 - r) ||
                bus.state !== ((r == 2) ? 2'd3 : 2'd2)) begin
                n_err++; $display("FAIL miss_r%0d: got y=%0d miss=%0b lives=%0d st=%0d", r,
                                  bus.ball_y, bus.miss, bus.lives, bus.state);
            end
            cyc(1'b0, 1'b1);
            #2;
            n_cmp++;
            if (bus.miss !== 1'b0 || bus.state !== ((r == 2) ? 2'd3 : 2'd2)) begin
                n_err++; $display("FAIL miss_hold_r%0d: got miss=%0b st=%0d", r, bus.miss, bus.state);
            end
            if (r < 2) begin
                ticks(59);
                n_cmp++;
                if (bus.state !== 2'd2 || bus.ball_x !== 10'd173) begin
                    n_err++; $display("FAIL miss_frozen_r%0d: got st=%0d x=%0d exp 2 173",
                                      r, bus.state, bus.ball_x);
                end
                ticks(1);
                n_cmp++;
                if (bus.state !== 2'd0 || bus.ball_x !== 10'd152 || bus.ball_y !== 10'd60) begin
                    n_err++; $display("FAIL miss_exit_r%0d: got st=%0d (%0d,%0d) exp 0 (152,60)",
                                      r, bus.state, bus.ball_x, bus.ball_y);
                end
            end
        end
        ticks(5);
        n_cmp++;
        if (bus.game_over !== 1'b1 || bus.lives !== 2'd0 || bus.ball_y !== 10'd225) begin
            n_err++; $display("FAIL over_hold: got go=%0b lives=%0d y=%0d exp 1 0 225",
                              bus.game_over, bus.lives, bus.ball_y);
        end
        do_reset();
        n_cmp++;
        if (bus.state !== 2'd0 || bus.lives !== 2'd3 || bus.game_over !== 1'b0) begin
            n_err++; $display("FAIL over_reset: got st=%0d lives=%0d go=%0b exp 0 3 0",
                              bus.state, bus.lives, bus.game_over);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.serve      = 1'b0;
        bus.board_pos  = 10'd0;
        model_reset();
        test_reset();
        test_serve_move();
        test_serve_with_tick();
        test_paddle();
        test_miss_over();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d entries exp 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
